// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and converter state type
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bcd2bin_state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  // Reverse double-dabble: after each right shift, digits >= 8 lose 3.
  localparam int R2B_THRESH = 8;
  localparam int R2B_ADJ    = 3;

  // Forward double-dabble (binary-to-BCD): digits >= 5 gain 3 before each shift.
  localparam int B2R_THRESH = 5;
  localparam int B2R_ADJ    = 3;

endpackage

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - per-digit correction for reverse double-dabble
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'(R2B_THRESH)) ? din - 4'(R2B_ADJ) : din;
  end

endmodule

// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - sequential BCD-to-binary converter, one shift/correct per clock
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   i_bcd,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [BIN_W-1:0]                o_bin,
  output logic                            o_err,
  output logic                            o_valid,
  input  logic                            i_ready
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  bcd2bin_state_t state, next_state;

  logic [BCD_W-1:0] sr_bcd;
  logic [BIN_W-1:0] sr_bin;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_corr;
  logic [BIN_W-1:0] bin_shift;
  logic             digit_bad;
  logic             accept;

  assign accept = i_valid && (state == IDLE);

  always_comb begin
    digit_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX_DIGIT)) begin
        digit_bad = 1'b1;
      end
    end
  end

  // {bcd, bin} shifts right as one register; bcd LSB falls into bin MSB.
  assign bcd_shift = sr_bcd >> 1;
  assign bin_shift = {sr_bcd[0], sr_bin[BIN_W-1:1]};

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .din  (bcd_shift[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_corr[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = digit_bad ? DONE : BUSY;
      BUSY: if (cnt == LAST_ITER) next_state = DONE;
      DONE: if (i_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_bcd <= '0;
      sr_bin <= '0;
      cnt    <= '0;
      o_bin  <= '0;
      o_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (digit_bad) begin
              o_bin <= '0;
              o_err <= 1'b1;
            end else begin
              sr_bcd <= i_bcd;
              sr_bin <= '0;
              cnt    <= '0;
              o_err  <= 1'b0;
            end
          end
        end
        BUSY: begin
          sr_bcd <= bcd_corr;
          sr_bin <= bin_shift;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ITER) o_bin <= bin_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - randomized self-checking bench for bcd2bin against an arithmetic model
module tb_bcd2bin;

  localparam int BIN_W = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_bcd = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [13:0] o_bin;
  logic        o_err;
  logic        o_valid;
  logic        i_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  bcd2bin dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_bcd   (i_bcd),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_bin   (o_bin),
    .o_err   (o_err),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decimal value of the digits; any digit above 9 flags an error and zeroes the result.
  function automatic void ref_model(input logic [15:0] v, output logic [13:0] b, output logic e);
    int acc;
    int scale;
    int d;
    acc = 0;
    scale = 1;
    e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = int'((v >> (4 * k)) & 16'hF);
      if (d > 9) e = 1'b1;
      acc += d * scale;
      scale *= 10;
    end
    b = e ? 14'd0 : 14'(acc);
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic run(input logic [15:0] v, input int hold);
    logic [13:0] eb;
    logic        ee;
    int          lat;
    ref_model(v, eb, ee);
    @(negedge clk);
    check("idle_ready", 32'(o_ready), 32'd1);
    i_bcd   = v;
    i_valid = 1'b1;
    i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    i_bcd   = 16'($urandom);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), ee ? 32'd0 : 32'(BIN_W));
    check("bin", 32'(o_bin), 32'(eb));
    check("err", 32'(o_err), 32'(ee));
    check("done_ready", 32'(o_ready), 32'd0);
    if (!ee) check("bcd_residue", 32'(dut.sr_bcd), 32'd0);
    for (int i = 0; i < hold; i++) begin
      i_valid = 1'b1;
      i_bcd   = 16'h0001;
      @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_ready", 32'(o_ready), 32'd0);
      check("hold_bin", 32'(o_bin), 32'(eb));
      check("hold_err", 32'(o_err), 32'(ee));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("post_ready", 32'(o_ready), 32'd1);
    check("post_valid", 32'(o_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [15:0] v;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_bin", 32'(o_bin), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(o_ready), 32'd1);
    check("rel_valid", 32'(o_valid), 32'd0);

    run(16'h9999, 0);
    run(16'h0000, 0);
    run(16'h1234, 1);
    run(16'h0042, 0);
    run(16'h12A4, 0);
    run(16'h0007, 0);
    run(16'h9999, 5);
    run(16'hFFFF, 2);

    // Abort during iteration 7 of 16'h5555.
    @(negedge clk);
    i_bcd   = 16'h5555;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_valid", 32'(o_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 32'd0);
    run(16'h5555, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) != 0) v = to_bcd(int'($urandom_range(9999)));
      else                        v = 16'($urandom);
      run(v, int'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
